// File: rtl/func_unit_if.sv
// Request/result bundle between the operand-read stage and the multi-cycle functional unit.
// The master drives the request and the slave (the functional unit) returns the result and flags.
interface func_unit_if #(
    parameter int SIZE = 16,
    parameter int CNTW = 2
);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic            bw;
    logic [CNTW-1:0] cnt;
    logic            cin;
    logic [SIZE-1:0] src;
    logic [SIZE-1:0] dst;
    logic            ready;
    logic            done;
    logic [SIZE-1:0] f_out;
    logic [SIZE-1:0] f_hi;
    logic [3:0]      cvnz;

    modport master (
        output start, flush, op, bw, cnt, cin, src, dst,
        input  ready, done, f_out, f_hi, cvnz
    );

    modport slave (
        input  start, flush, op, bw, cnt, cin, src, dst,
        output ready, done, f_out, f_hi, cvnz
    );
endinterface

// File: rtl/func_unit_seq.sv
// Multi-cycle MSP430-style functional unit: single-cycle ALU ops, bit-serial shifts/rotates
// and a shift-add multiplier. Each step works from either the live inputs (first step) or the working registers.
module func_unit_seq #(
    parameter int SIZE = 16,
    parameter int CNTW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    func_unit_if.slave  bus
);
    localparam int H  = SIZE / 2;
    localparam int RW = ($clog2(SIZE) > CNTW) ? $clog2(SIZE) : CNTW;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDC = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_RRA  = 3'd4;
    localparam logic [2:0] OP_RRC  = 3'd5;
    localparam logic [2:0] OP_MPY  = 3'd7;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg, op_next;
    logic              bw_reg, bw_next;
    logic              carry_reg, carry_next;
    logic [RW-1:0]     rem_reg, rem_next;
    logic [2*SIZE-1:0] acc_reg, acc_next;
    logic [2*SIZE-1:0] mcand_reg, mcand_next;
    logic [SIZE-1:0]   mplier_reg, mplier_next;
    logic              done_reg, done_next;
    logic [SIZE-1:0]   f_out_reg, f_out_next;
    logic [SIZE-1:0]   f_hi_reg, f_hi_next;
    logic [3:0]        cvnz_reg, cvnz_next;

    logic [SIZE-1:0] lo_mask;
    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_mask
            assign lo_mask[gi] = (gi < H);
        end
    endgenerate

    logic            idle, accept;
    logic [SIZE-1:0] src_m, dst_m;
    assign idle   = (state_reg == IDLE);
    assign accept = idle && bus.start && !bus.flush;
    assign src_m  = bus.bw ? (bus.src & lo_mask) : bus.src;
    assign dst_m  = bus.bw ? (bus.dst & lo_mask) : bus.dst;

    // ALU path: byte mode has its own narrow adder so carry/overflow come from bit H-1.
    logic [SIZE-1:0] b_op, alu_res;
    logic            ci, alu_c, alu_v, alu_n, alu_z;
    logic [SIZE:0]   sum_w;
    logic [H:0]      sum_b;
    assign b_op  = (bus.op == OP_SUB) ? ~src_m : src_m;
    assign ci    = (bus.op == OP_SUB) || ((bus.op == OP_ADDC) && bus.cin);
    assign sum_w = {1'b0, dst_m} + {1'b0, b_op} + {{SIZE{1'b0}}, ci};
    assign sum_b = {1'b0, dst_m[H-1:0]} + {1'b0, b_op[H-1:0]} + {{H{1'b0}}, ci};

    always_comb begin
        alu_res = sum_w[SIZE-1:0];
        alu_c   = sum_w[SIZE];
        alu_v   = (dst_m[SIZE-1] == b_op[SIZE-1]) && (sum_w[SIZE-1] != dst_m[SIZE-1]);
        if (bus.bw) begin
            alu_res = {{(SIZE-H){1'b0}}, sum_b[H-1:0]};
            alu_c   = sum_b[H];
            alu_v   = (dst_m[H-1] == b_op[H-1]) && (sum_b[H-1] != dst_m[H-1]);
        end
        if (bus.op == OP_AND) begin
            alu_res = dst_m & src_m;
        end
        alu_n = bus.bw ? alu_res[H-1] : alu_res[SIZE-1];
        alu_z = (alu_res == '0);
        if (bus.op == OP_AND) begin
            alu_c = !alu_z;
            alu_v = 1'b0;
        end
    end

    logic [2:0]        cur_op;
    logic              cur_bw, cur_c, last;
    logic [SIZE-1:0]   cur_val, sh_val, cur_mplier;
    logic [2*SIZE-1:0] cur_acc, cur_mcand, mul_acc;
    logic [RW-1:0]     rem_cur, rem_init;
    logic              sh_out, sh_n, sh_z;
    assign cur_op     = idle ? bus.op : op_reg;
    assign cur_bw     = idle ? bus.bw : bw_reg;
    assign cur_c      = idle ? bus.cin : carry_reg;
    assign cur_val    = idle ? dst_m : acc_reg[SIZE-1:0];
    assign cur_acc    = idle ? '0 : acc_reg;
    assign cur_mcand  = idle ? {{SIZE{1'b0}}, src_m} : mcand_reg;
    assign cur_mplier = idle ? dst_m : mplier_reg;
    assign rem_init   = (bus.op == OP_MPY) ? (bus.bw ? RW'(H - 1) : RW'(SIZE - 1)) : RW'(bus.cnt);
    assign rem_cur    = idle ? rem_init : rem_reg;
    assign last       = (rem_cur == '0);
    assign mul_acc    = cur_acc + (cur_mplier[0] ? cur_mcand : '0);

    always_comb begin
        sh_val = cur_val >> 1;
        sh_out = cur_val[0];
        case (cur_op)
            OP_RRA: begin
                if (cur_bw) sh_val[H-1] = cur_val[H-1];
                else        sh_val[SIZE-1] = cur_val[SIZE-1];
            end
            OP_RRC: begin
                if (cur_bw) sh_val[H-1] = cur_c;
                else        sh_val[SIZE-1] = cur_c;
            end
            default: begin
                sh_val = cur_val << 1;
                sh_out = cur_val[SIZE-1];
                if (cur_bw) begin
                    sh_val = sh_val & lo_mask;
                    sh_out = cur_val[H-1];
                end
            end
        endcase
        sh_n = cur_bw ? sh_val[H-1] : sh_val[SIZE-1];
        sh_z = (sh_val == '0);
    end

    logic stepping;
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        bw_next     = bw_reg;
        carry_next  = carry_reg;
        rem_next    = rem_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        done_next   = 1'b0;
        f_out_next  = f_out_reg;
        f_hi_next   = f_hi_reg;
        cvnz_next   = cvnz_reg;
        stepping    = 1'b0;

        if (idle) begin
            if (accept) begin
                op_next = bus.op;
                bw_next = bus.bw;
                if (!bus.op[2]) begin
                    f_out_next = alu_res;
                    f_hi_next  = '0;
                    cvnz_next  = {alu_c, alu_v, alu_n, alu_z};
                    done_next  = 1'b1;
                end else begin
                    stepping = 1'b1;
                end
            end
        end else if (bus.flush) begin
            state_next = IDLE;
        end else begin
            stepping = 1'b1;
        end

        // The first step happens on the accepting edge, so the busy state lasts one cycle less than the step count.
        if (stepping) begin
            if (cur_op == OP_MPY) begin
                acc_next    = mul_acc;
                mcand_next  = cur_mcand << 1;
                mplier_next = cur_mplier >> 1;
                if (last) begin
                    f_out_next = mul_acc[SIZE-1:0];
                    f_hi_next  = cur_bw ? '0 : mul_acc[2*SIZE-1:SIZE];
                    cvnz_next  = {3'b000, (mul_acc == '0)};
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = MUL;
                    rem_next   = rem_cur - RW'(1);
                end
            end else begin
                acc_next   = {{SIZE{1'b0}}, sh_val};
                carry_next = sh_out;
                if (last) begin
                    f_out_next = sh_val;
                    f_hi_next  = '0;
                    cvnz_next  = {sh_out, 1'b0, sh_n, sh_z};
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = SHIFT;
                    rem_next   = rem_cur - RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            bw_reg     <= 1'b0;
            carry_reg  <= 1'b0;
            rem_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            done_reg   <= 1'b0;
            f_out_reg  <= '0;
            f_hi_reg   <= '0;
            cvnz_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            bw_reg     <= bw_next;
            carry_reg  <= carry_next;
            rem_reg    <= rem_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            done_reg   <= done_next;
            f_out_reg  <= f_out_next;
            f_hi_reg   <= f_hi_next;
            cvnz_reg   <= cvnz_next;
        end
    end

    assign bus.ready = (state_reg == IDLE) || done_reg;
    assign bus.done  = done_reg;
    assign bus.f_out = f_out_reg;
    assign bus.f_hi  = f_hi_reg;
    assign bus.cvnz  = cvnz_reg;
endmodule

// File: tb/tb_func_unit_seq.sv
// Bench for func_unit_seq: table of hand-computed vectors fed through a scoreboard,
// plus hand-written flush and mid-operation reset sequences.
module tb_func_unit_seq;
    localparam int SIZE = 16;
    localparam int CNTW = 2;
    localparam int NV   = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    func_unit_if #(.SIZE(SIZE), .CNTW(CNTW)) bus ();
    func_unit_seq #(.SIZE(SIZE), .CNTW(CNTW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic        bw;
        logic [1:0]  cnt;
        logic        cin;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] e_out;
        logic [15:0] e_hi;
        logic [3:0]  e_cvnz;
    } vec_t;

    typedef struct {
        logic [15:0] e_out;
        logic [15:0] e_hi;
        logic [3:0]  e_cvnz;
        int          due;
        int          id;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(logic [2:0] op, logic bw, logic [1:0] cnt, logic cin,
                                logic [15:0] src, logic [15:0] dst,
                                logic [15:0] e_out, logic [15:0] e_hi, logic [3:0] e_cvnz);
        vec_t v;
        v.op = op; v.bw = bw; v.cnt = cnt; v.cin = cin; v.src = src; v.dst = dst;
        v.e_out = e_out; v.e_hi = e_hi; v.e_cvnz = e_cvnz;
        return v;
    endfunction

    function automatic int lat(vec_t v);
        if (!v.op[2]) return 1;
        if (v.op == 3'b111) return v.bw ? SIZE / 2 : SIZE;
        return int'(v.cnt) + 1;
    endfunction

    // Scoreboard monitor: every done pops one expectation, including its due cycle.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %0d: f_out=%h f_hi=%h cvnz=%b cycle=%0d", e.id, bus.f_out, bus.f_hi, bus.cvnz, cyc);
                chk($sformatf("f_out[%0d]", e.id), 32'(bus.f_out), 32'(e.e_out));
                chk($sformatf("f_hi[%0d]", e.id), 32'(bus.f_hi), 32'(e.e_hi));
                chk($sformatf("cvnz[%0d]", e.id), 32'(bus.cvnz), 32'(e.e_cvnz));
                chk($sformatf("latency[%0d]", e.id), 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic issue(vec_t v);
        exp_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ready) chk("ready_timeout", 32'(bus.ready), 32'd1);
        bus.start = 1'b1; bus.op = v.op; bus.bw = v.bw; bus.cnt = v.cnt;
        bus.cin = v.cin; bus.src = v.src; bus.dst = v.dst;
        e.e_out = v.e_out; e.e_hi = v.e_hi; e.e_cvnz = v.e_cvnz;
        e.due = cyc + lat(v);
        e.id = txn++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble operands after acceptance so results depend only on latched values.
        bus.start = 1'b0;
        bus.op = 3'($urandom); bus.bw = 1'($urandom); bus.cnt = 2'($urandom);
        bus.cin = 1'($urandom); bus.src = 16'($urandom); bus.dst = 16'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int c;
        vecs[0]  = mk(3'd0, 1'b0, 2'd0, 1'b0, 16'h0001, 16'h7FFF, 16'h8000, 16'h0000, 4'b0110);
        vecs[1]  = mk(3'd2, 1'b0, 2'd0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b1001);
        vecs[2]  = mk(3'd1, 1'b0, 2'd0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 4'b0000);
        vecs[3]  = mk(3'd4, 1'b1, 2'd2, 1'b0, 16'h0000, 16'h0081, 16'h00F0, 16'h0000, 4'b0010);
        vecs[4]  = mk(3'd5, 1'b0, 2'd0, 1'b1, 16'h0000, 16'h0001, 16'h8000, 16'h0000, 4'b1010);
        vecs[5]  = mk(3'd7, 1'b0, 2'd0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0000);
        vecs[6]  = mk(3'd7, 1'b1, 2'd0, 1'b0, 16'hAB02, 16'h12FF, 16'h01FE, 16'h0000, 4'b0000);
        vecs[7]  = mk(3'd0, 1'b1, 2'd0, 1'b0, 16'h3401, 16'h12FF, 16'h0000, 16'h0000, 4'b1001);
        vecs[8]  = mk(3'd2, 1'b0, 2'd0, 1'b0, 16'h0005, 16'h0003, 16'hFFFE, 16'h0000, 4'b0010);
        vecs[9]  = mk(3'd3, 1'b0, 2'd0, 1'b0, 16'h0F0F, 16'hF0F0, 16'h0000, 16'h0000, 4'b0001);
        vecs[10] = mk(3'd3, 1'b0, 2'd0, 1'b0, 16'hFFFF, 16'h8001, 16'h8001, 16'h0000, 4'b1010);
        vecs[11] = mk(3'd6, 1'b0, 2'd1, 1'b0, 16'h0000, 16'hC001, 16'h0004, 16'h0000, 4'b1000);
        vecs[12] = mk(3'd6, 1'b1, 2'd3, 1'b0, 16'h0000, 16'hAAC0, 16'h0000, 16'h0000, 4'b0001);
        vecs[13] = mk(3'd5, 1'b1, 2'd1, 1'b0, 16'h0000, 16'hFF02, 16'h0000, 16'h0000, 4'b1001);
        vecs[14] = mk(3'd1, 1'b1, 2'd0, 1'b1, 16'h3400, 16'h127F, 16'h0080, 16'h0000, 4'b0110);
        vecs[15] = mk(3'd4, 1'b0, 2'd3, 1'b0, 16'h0000, 16'h8000, 16'hF800, 16'h0000, 4'b0010);
        vecs[16] = mk(3'd7, 1'b0, 2'd0, 1'b0, 16'h0010, 16'h1234, 16'h2340, 16'h0001, 4'b0000);
        vecs[17] = mk(3'd7, 1'b0, 2'd0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 4'b0001);
        vecs[18] = mk(3'd0, 1'b0, 2'd0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0000, 4'b1010);

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.bw = 1'b0;
        bus.cnt = 2'd0; bus.cin = 1'b0; bus.src = 16'h0; bus.dst = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_f_out", 32'(bus.f_out), 32'd0);
        chk("rst_f_hi", 32'(bus.f_hi), 32'd0);
        chk("rst_cvnz", 32'(bus.cvnz), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) issue(vecs[i]);
        drain();

        // MPY with an ignored start at cycle 3 and a flush at cycle 5
        @(negedge clk);
        c = cyc;
        bus.start = 1'b1; bus.op = 3'd7; bus.bw = 1'b0; bus.src = 16'h0003; bus.dst = 16'h0007;
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (cyc < c + 3) @(negedge clk);
        chk("mpy_busy_ready", 32'(bus.ready), 32'd0);
        bus.start = 1'b1; bus.op = 3'd0; bus.src = 16'h0001; bus.dst = 16'h0001;
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (cyc < c + 5) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", 32'(bus.ready), 32'd1);
        chk("flush_done", 32'(bus.done), 32'd0);
        chk("flush_f_out", 32'(bus.f_out), 32'(vecs[NV-1].e_out));
        chk("flush_f_hi", 32'(bus.f_hi), 32'(vecs[NV-1].e_hi));
        chk("flush_cvnz", 32'(bus.cvnz), 32'(vecs[NV-1].e_cvnz));
        repeat (25) @(negedge clk);

        // Flush in IDLE blocks a coincident start
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.src = 16'h0001; bus.dst = 16'h0002;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
        @(negedge clk);
        chk("idle_flush_done", 32'(bus.done), 32'd0);
        chk("idle_flush_f_out", 32'(bus.f_out), 32'(vecs[NV-1].e_out));
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a shift
        bus.start = 1'b1; bus.op = 3'd6; bus.bw = 1'b0; bus.cnt = 2'd3; bus.dst = 16'h1234;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("shift_busy_ready", 32'(bus.ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.ready), 32'd1);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_f_out", 32'(bus.f_out), 32'd0);
        chk("arst_f_hi", 32'(bus.f_hi), 32'd0);
        chk("arst_cvnz", 32'(bus.cvnz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(mk(3'd0, 1'b0, 2'd0, 1'b0, 16'h2222, 16'h1111, 16'h3333, 16'h0000, 4'b0000));
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/func_unit_seq.md
# func_unit_seq

Multi-cycle successor to the MSP430 functional unit. It provides single-cycle ALU operations, multi-bit shifts/rotates (one bit per cycle, MSP430X RxxM style) and an iterative unsigned shift-add multiplier, all behind a start/done handshake. It sits between the operand/register-file read stage and the writeback path, and returns a SIZE-bit result, a high result word (multiply only) and CVNZ flags for the status register.

## Interface
- SIZE, 16: operand/result width; must be even (byte mode uses the low SIZE/2 bits).
- CNTW, 2: shift-count field width; shift amount = cnt+1, so 1..2^CNTW.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  request; accepted only when ready=1.
- flush  in  1  synchronous abort; dominates start.
- op  in  3  000 ADD, 001 ADDC, 010 SUB, 011 AND, 100 RRA, 101 RRC, 110 RLA, 111 MPY.
- bw  in  1  1 = byte mode.
- cnt  in  CNTW  shift amount minus 1 (ops 100–110 only).
- cin  in  1  carry in for ADDC and RRC.
- src, dst  in  SIZE  operands.
- ready  out  1  can accept start.
- done  out  1  one-cycle result-valid pulse.
- f_out  out  SIZE  result (low product word for MPY).
- f_hi  out  SIZE  high product word; 0 for all non-MPY ops.
- cvnz  out  4  [3]=C, [2]=V, [1]=N, [0]=Z.

## Operation
- States: IDLE, SHIFT, MUL. All of op/bw/cnt/cin/src/dst are latched on an accepted start; later input changes are ignored.
- ADD/ADDC/SUB/AND complete from IDLE with no state change: the result is registered and done=1 on the next edge.
  - ADD: dst+src. ADDC: dst+src+cin. SUB: dst+~src+1.
  - C = carry out of the MSB; for SUB, C=1 means no borrow.
  - V = signed overflow; N = MSB; Z = result==0.
  - AND: C=~Z, V=0.
- RRA/RRC/RLA: IDLE→SHIFT. A down-counter is loaded with cnt, one bit is shifted per cycle, then SHIFT→IDLE with done.
  - RRA replicates the MSB.
  - RRC shifts the carry register in, initialised from cin.
  - RLA shifts in 0.
  - C = last bit shifted out, V=0, N/Z from the result.
- MPY: IDLE→MUL. Unsigned shift-add, one multiplier bit per cycle. Product = {f_hi,f_out}. C=V=N=0, Z = full product==0.
- Byte mode (bw=1):
  - Only the low SIZE/2 bits of each operand are used.
  - C/N come from bit SIZE/2-1 (the carry out of bit SIZE/2-1 for arithmetic).
  - The result's upper half is 0.
  - MPY runs SIZE/2 cycles, the SIZE-bit product goes in f_out, and f_hi=0.
- f_out/f_hi/cvnz change only on the edge that raises done; they hold their values otherwise, including during SHIFT/MUL and after a flush. Working registers are separate.
- ready = (state==IDLE) or (done cycle). A start in the done cycle is accepted, so ALU ops sustain one per cycle.
- start while ready=0: ignored, with no queueing.
- flush=1 in SHIFT/MUL: go to IDLE at the next edge, no done, outputs unchanged. flush in IDLE: any coincident start is ignored.
- Async reset, including mid-operation: state=IDLE, ready=1, done=0, f_out=0, f_hi=0, cvnz=0, counters cleared.

## Timing
- ALU ops: start at edge k → done=1 in cycle k+1.
- Shifts: done in cycle k+cnt+1 (cnt+1 cycles latency); ready=0 for cycles k+1..k+cnt.
- MPY: done in cycle k+SIZE (word) or k+SIZE/2 (byte); ready=0 until then.
- done is high for exactly one cycle per accepted start that is not flushed.
- A flush seen at edge j gives ready=1 in cycle j+1.

## Test plan
- ADD word, dst=0x7FFF, src=0x0001 → done in the next cycle, f_out=0x8000, cvnz=0110, f_hi=0.
- SUB word, dst=0x0005, src=0x0005 → f_out=0x0000, cvnz=1001. Then ADDC back-to-back on the done cycle with cin=1, dst=src=0x0000 → f_out=0x0001, cvnz=0000.
- RRA byte, dst=0x0081, cnt=2 → done 3 cycles after start, f_out=0x00F0, cvnz=0010. RRC word, dst=0x0001, cin=1, cnt=0 → f_out=0x8000, cvnz=1010.
- MPY word, src=dst=0xFFFF → done 16 cycles after start, f_hi=0xFFFE, f_out=0x0001, cvnz=0000. MPY byte, 0x00FF×0x0002 → done after 8 cycles, f_out=0x01FE.
- During MPY: a start at cycle 3 is ignored; flush at cycle 5 → no done, ready=1 next cycle, f_out/cvnz keep their prior values.
- rst_n low mid-SHIFT → immediately ready=1, done=0, f_out=f_hi=0, cvnz=0. After release, an ADD completes normally.
